// File: rtl/mmp_iddmm_arb.sv
// Round-robin arbiter/sequencer sharing one IDDMM Montgomery core between NREQ requesters:
// streams the winner's operands into the core RAMs, starts the task and routes result words back.
module mmp_iddmm_arb #(
  parameter int unsigned K      = 128,
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = $clog2(N),
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IDW    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  output logic [ADDR_W-1:0]   op_addr,
  input  logic [NREQ*K-1:0]   op_x,
  input  logic [NREQ*K-1:0]   op_y,
  input  logic [NREQ*K-1:0]   op_m,
  input  logic [NREQ*K-1:0]   op_m1,
  output logic [2:0]          core_wr_ena,
  output logic [ADDR_W-1:0]   core_wr_addr,
  output logic [K-1:0]        core_wr_x,
  output logic [K-1:0]        core_wr_y,
  output logic [K-1:0]        core_wr_m,
  output logic [K-1:0]        core_wr_m1,
  output logic                core_task_req,
  input  logic                core_task_grant,
  input  logic [K-1:0]        core_task_res,
  input  logic                core_task_end,
  output logic                res_valid,
  output logic [K-1:0]        res_data,
  output logic [ADDR_W-1:0]   res_addr,
  output logic [IDW-1:0]      res_id,
  output logic [NREQ-1:0]     done,
  output logic                err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

  state_t            state;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    win;
  logic              iss;
  logic              smp;
  logic [ADDR_W-1:0] smp_addr;
  logic [ADDR_W-1:0] cnt;
  logic              seen_all;
  logic              ovf;

  logic [IDW-1:0]    pick_c;
  logic              any_c;
  logic [K-1:0]      x_win_c;
  logic [K-1:0]      y_win_c;
  logic [K-1:0]      m_win_c;
  logic [K-1:0]      m1_win_c;
  logic [K-1:0]      m1_pick_c;
  logic [ADDR_W-1:0] cnt_inc_c;
  logic              seen_nxt_c;
  logic              ovf_nxt_c;

  // First set request at or above ptr, searching upward with wrap
  always_comb begin
    int unsigned j;
    pick_c = '0;
    any_c  = 1'b0;
    j      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any_c && req[IDW'(j)]) begin
        any_c  = 1'b1;
        pick_c = IDW'(j);
      end
    end
  end

  always_comb begin
    x_win_c   = op_x[32'(win) * K +: K];
    y_win_c   = op_y[32'(win) * K +: K];
    m_win_c   = op_m[32'(win) * K +: K];
    m1_win_c  = op_m1[32'(win) * K +: K];
    m1_pick_c = op_m1[32'(pick_c) * K +: K];
  end

  // Result-word accounting: seen_all marks N words, any word beyond that is an overflow
  always_comb begin
    cnt_inc_c  = (cnt == LAST) ? '0 : cnt + ADDR_W'(1);
    seen_nxt_c = seen_all | (core_task_grant && cnt == LAST);
    ovf_nxt_c  = ovf | (core_task_grant && seen_all);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      win           <= '0;
      iss           <= 1'b0;
      smp           <= 1'b0;
      smp_addr      <= '0;
      cnt           <= '0;
      seen_all      <= 1'b0;
      ovf           <= 1'b0;
      gnt           <= '0;
      op_addr       <= '0;
      core_wr_ena   <= '0;
      core_wr_addr  <= '0;
      core_wr_x     <= '0;
      core_wr_y     <= '0;
      core_wr_m     <= '0;
      core_wr_m1    <= '0;
      core_task_req <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_addr      <= '0;
      res_id        <= '0;
      done          <= '0;
      err           <= 1'b0;
    end else begin
      res_valid     <= 1'b0;
      done          <= '0;
      err           <= 1'b0;
      core_task_req <= 1'b0;
      core_wr_ena   <= '0;
      case (state)
        IDLE: begin
          if (any_c) begin
            win        <= pick_c;
            gnt        <= NREQ'(1) << pick_c;
            op_addr    <= '0;
            iss        <= 1'b1;
            smp        <= 1'b0;
            cnt        <= '0;
            seen_all   <= 1'b0;
            ovf        <= 1'b0;
            core_wr_m1 <= m1_pick_c;
            state      <= LOAD;
          end
        end
        LOAD: begin
          core_wr_m1 <= m1_win_c;
          // Address issue stage; requester data for that address arrives one cycle later
          if (iss) begin
            smp      <= 1'b1;
            smp_addr <= op_addr;
            if (op_addr == LAST) iss <= 1'b0;
            else                 op_addr <= op_addr + ADDR_W'(1);
          end else begin
            smp <= 1'b0;
          end
          if (smp) begin
            core_wr_ena  <= 3'b111;
            core_wr_addr <= smp_addr;
            core_wr_x    <= x_win_c;
            core_wr_y    <= y_win_c;
            core_wr_m    <= m_win_c;
            if (smp_addr == LAST) state <= START;
          end
        end
        START: begin
          core_wr_m1    <= m1_win_c;
          core_task_req <= 1'b1;
          state         <= RUN;
        end
        RUN: begin
          core_wr_m1 <= m1_win_c;
          if (core_task_grant) begin
            res_valid <= 1'b1;
            res_data  <= core_task_res;
            res_addr  <= cnt;
            res_id    <= win;
            cnt       <= cnt_inc_c;
            seen_all  <= seen_nxt_c;
            ovf       <= ovf_nxt_c;
          end
          if (core_task_end) begin
            done  <= NREQ'(1) << win;
            err   <= ~seen_nxt_c | ovf_nxt_c;
            state <= DONE;
          end
        end
        DONE: begin
          gnt        <= '0;
          core_wr_m1 <= '0;
          ptr        <= (32'(win) == NREQ - 1) ? '0 : win + IDW'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmp_iddmm_arb.sv
// Randomized self-checking bench for mmp_iddmm_arb: requester RAMs, a scripted core model
// and a transaction-level arbitration/accounting reference.
module tb_mmp_iddmm_arb;

  localparam int K      = 128;
  localparam int N      = 32;
  localparam int NREQ   = 4;
  localparam int ADDR_W = $clog2(N);
  localparam int IDW    = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [ADDR_W-1:0]   op_addr;
  logic [NREQ*K-1:0]   op_x, op_y, op_m, op_m1;
  logic [2:0]          core_wr_ena;
  logic [ADDR_W-1:0]   core_wr_addr;
  logic [K-1:0]        core_wr_x, core_wr_y, core_wr_m, core_wr_m1;
  logic                core_task_req;
  logic                core_task_grant;
  logic [K-1:0]        core_task_res;
  logic                core_task_end;
  logic                res_valid;
  logic [K-1:0]        res_data;
  logic [ADDR_W-1:0]   res_addr;
  logic [IDW-1:0]      res_id;
  logic [NREQ-1:0]     done;
  logic                err;

  logic [K-1:0] mx [NREQ][N];
  logic [K-1:0] my [NREQ][N];
  logic [K-1:0] mm [NREQ][N];
  logic [K-1:0] m1v [NREQ];

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  mmp_iddmm_arb #(.K(K), .N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .op_addr(op_addr),
    .op_x(op_x), .op_y(op_y), .op_m(op_m), .op_m1(op_m1),
    .core_wr_ena(core_wr_ena), .core_wr_addr(core_wr_addr),
    .core_wr_x(core_wr_x), .core_wr_y(core_wr_y), .core_wr_m(core_wr_m), .core_wr_m1(core_wr_m1),
    .core_task_req(core_task_req), .core_task_grant(core_task_grant),
    .core_task_res(core_task_res), .core_task_end(core_task_end),
    .res_valid(res_valid), .res_data(res_data), .res_addr(res_addr), .res_id(res_id),
    .done(done), .err(err)
  );

  // Requester operand RAMs, one-cycle read latency
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      op_x[i*K +: K] <= mx[i][op_addr];
      op_y[i*K +: K] <= my[i][op_addr];
      op_m[i*K +: K] <= mm[i][op_addr];
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) op_m1[i*K +: K] = m1v[i];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [K-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk(tag, 128'({|gnt, |done, err, res_valid, core_task_req, |core_wr_ena, |op_addr,
                   |core_wr_addr, |res_addr, |res_id, |core_wr_x, |core_wr_y, |core_wr_m,
                   |core_wr_m1, |res_data}), 128'(0));
  endtask

  task automatic idle_inject(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      core_task_grant = 1'($urandom_range(0, 1));
      core_task_end   = 1'($urandom_range(0, 1));
      core_task_res   = rand_word();
      @(negedge clk);
      chk("idle_res_valid", 128'(res_valid), 128'(0));
      chk("idle_done", 128'(done), 128'(0));
      chk("idle_gnt", 128'(gnt), 128'(0));
    end
    core_task_grant = 1'b0;
    core_task_end   = 1'b0;
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks outputs clear before any clock edge
  task automatic rst_pulse(input string tag);
    #2;
    rst = 1'b1;
    req = '0;
    core_task_grant = 1'b0;
    core_task_end   = 1'b0;
    #1;
    chk_all_zero(tag);
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  // One full grant, entered at a negedge with the DUT idle and req non-zero
  task automatic txn(input int nw, input bit end_with_last, input bit release_win,
                     input logic [NREQ-1:0] add_mask);
    int w, cyc, wc, sent, ea, guard;
    bit seen_req, ended, ev;
    logic [K-1:0] ed;
    w   = pick(req, m_ptr);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == '0 && cyc < 40);
    chk("gnt_wait", 128'(cyc < 40), 128'(1));
    if (cyc >= 40) return;
    chk("gnt_latency", 128'(cyc), 128'(1));
    chk("gnt_onehot", 128'(gnt), 128'(1) << w);

    wc = 0;
    seen_req = 1'b0;
    for (int c = 0; c < N + 6 && !seen_req; c++) begin
      if (c == 1) chk("wr_m1", 128'(core_wr_m1), 128'(m1v[w]));
      if (core_wr_ena != 3'b000) begin
        chk("wr_ena", 128'(core_wr_ena), 128'(3'b111));
        chk("wr_addr", 128'(core_wr_addr), 128'(wc % N));
        chk("wr_x", 128'(core_wr_x), 128'(mx[w][wc % N]));
        chk("wr_y", 128'(core_wr_y), 128'(my[w][wc % N]));
        chk("wr_m", 128'(core_wr_m), 128'(mm[w][wc % N]));
        wc++;
      end
      if (core_task_req) begin
        seen_req = 1'b1;
        chk("start_latency", 128'(c), 128'(N + 2));
      end
      @(negedge clk);
    end
    chk("start_seen", 128'(seen_req), 128'(1));
    chk("wr_count", 128'(wc), 128'(N));
    chk("task_req_pulse", 128'(core_task_req), 128'(0));
    if (!seen_req) return;

    m_ptr = (w + 1) % NREQ;
    req   = req | add_mask;
    sent  = 0;
    ended = 1'b0;
    guard = 0;
    while (!ended) begin
      ev = 1'b0;
      core_task_grant = 1'b0;
      core_task_end   = 1'b0;
      if (sent < nw && ($urandom_range(0, 3) != 0 || guard > 200)) begin
        ed = rand_word();
        core_task_grant = 1'b1;
        core_task_res   = ed;
        ea = sent % N;
        sent++;
        ev = 1'b1;
        if (sent == nw && end_with_last) core_task_end = 1'b1;
      end else if (sent == nw) begin
        core_task_end = 1'b1;
      end
      ended = core_task_end;
      guard++;
      @(negedge clk);
      core_task_grant = 1'b0;
      core_task_end   = 1'b0;
      chk("res_valid", 128'(res_valid), 128'(ev));
      if (ev) begin
        chk("res_data", 128'(res_data), 128'(ed));
        chk("res_addr", 128'(res_addr), 128'(ea));
        chk("res_id", 128'(res_id), 128'(w));
      end
      if (!ended) chk("done_early", 128'(done), 128'(0));
    end
    chk("done", 128'(done), 128'(1) << w);
    chk("err", 128'(err), 128'(nw != N));
    chk("gnt_hold", 128'(gnt), 128'(1) << w);
    if (release_win) req[w] = 1'b0;
    @(negedge clk);
    chk("gnt_clear", 128'(gnt), 128'(0));
    chk("done_pulse", 128'(done), 128'(0));
  endtask

  initial begin
    int cyc;
    bit seen;
    int nw;
    for (int i = 0; i < NREQ; i++) begin
      m1v[i] = rand_word();
      for (int a = 0; a < N; a++) begin
        mx[i][a] = rand_word();
        my[i][a] = rand_word();
        mm[i][a] = rand_word();
      end
    end
    rst = 1'b1;
    req = '0;
    core_task_grant = 1'b0;
    core_task_end   = 1'b0;
    core_task_res   = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Requester 0 alone, x = y = 1, odd modulus
    for (int a = 0; a < N; a++) begin
      mx[0][a] = (a == 0) ? K'(1) : K'(0);
      my[0][a] = (a == 0) ? K'(1) : K'(0);
    end
    mm[0][0][0] = 1'b1;
    req = 4'b0001;
    txn(N, 1'b0, 1'b1, '0);

    idle_inject(6);

    // Reset while loading address 10
    req = 4'b0001;
    cyc = 0;
    while (!(op_addr == ADDR_W'(10) && gnt != '0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("load_addr10", 128'(op_addr), 128'(10));
    rst_pulse("rst_during_load");
    idle_inject(6);

    // All four requesting, held: 0,1,2,3 then 0 again
    req = 4'b1111;
    for (int t = 0; t < 5; t++) txn(N, 1'($urandom_range(0, 1)), 1'b0, '0);
    req = '0;
    @(negedge clk);

    // Serve 2 so ptr lands on 3, then 1001 must wrap to 3 before 0
    req = 4'b0100;
    txn(N, 1'b0, 1'b1, '0);
    req = 4'b1001;
    txn(N, 1'b1, 1'b1, '0);
    txn(N, 1'b0, 1'b1, '0);

    // Short and long result streams
    req = 4'b0010;
    txn(N - 1, 1'b0, 1'b0, '0);
    txn(N + 1, 1'b1, 1'b1, '0);

    // Reset while the core is running
    req = 4'b0010;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      seen = core_task_req;
      cyc++;
    end
    chk("run_reached", 128'(seen), 128'(1));
    for (int b = 0; b < 3; b++) begin
      core_task_grant = 1'b1;
      core_task_res   = rand_word();
      @(negedge clk);
    end
    core_task_grant = 1'b1;
    rst_pulse("rst_during_run");
    idle_inject(8);

    // Randomized traffic
    for (int t = 0; t < 20; t++) begin
      if (req == '0) req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      case ($urandom_range(0, 9))
        0:       nw = N - 1;
        1:       nw = N + 1;
        default: nw = N;
      endcase
      txn(nw, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmp_iddmm_arb.md
# mmp_iddmm_arb

Round-robin arbiter and sequencer that shares one IDDMM Montgomery multiplier core (x·y·r⁻¹ mod m, N words of K bits) between NREQ requesters. The granted requester's operands x, y, m are streamed word by word into the core's operand RAMs, along with its m1 constant. The block then issues the start pulse and routes the result words back, tagged with the requester index. It sits between the exponentiation engines and a single multiplier core.

## Interface
- K, 128, bits per word.
- N, 32, words per operand.
- ADDR_W, $clog2(N), word-address width.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), requester-index width.

Ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  request per requester; must be held until its done pulse.
- gnt  out  NREQ  one-hot grant, held from arbitration until done.
- op_addr  out  ADDR_W  word address presented to the winner.
- op_x, op_y, op_m  in  NREQ*K  per-requester operand words; slice i = [i*K +: K].
- op_m1  in  NREQ*K  per-requester m1; the winner's slice must be stable for the whole grant.
- core_wr_ena  out  3  write enables to the core's x/y/m RAMs.
- core_wr_addr  out  ADDR_W  core write address.
- core_wr_x, core_wr_y, core_wr_m, core_wr_m1  out  K each  core write data.
- core_task_req  out  1  core start pulse.
- core_task_grant  in  1  core result word valid.
- core_task_res  in  K  core result word.
- core_task_end  in  1  core completion pulse.
- res_valid  out  1  result word valid.
- res_data  out  K  result word.
- res_addr  out  ADDR_W  result word index, low word first.
- res_id  out  IDW  index of the owning requester.
- done  out  NREQ  one-cycle completion pulse to the owner.
- err  out  1  valid with done; set when the result word count was not equal to N.

## Operation
- States: IDLE, LOAD, START, RUN, DONE.
- IDLE:
  - If any req bit is set, select the first set bit at or after the round-robin pointer ptr, searching upward with wrap.
  - Register the winner index `win`, set gnt[win], clear the word counter, go to LOAD.
- LOAD:
  - op_addr steps 0..N-1, one address per cycle.
  - Requester data for op_addr=a is sampled one cycle later (same latency as a 1-cycle RAM read).
  - On that sample: core_wr_ena=3'b111, core_wr_addr=a, core_wr_x/y/m = winner slices.
  - After the write to address N-1, go to START.
- core_wr_m1 = winner's op_m1 slice for the whole grant; it is 0 when no grant is held.
- START: core_task_req=1 for exactly one cycle, then go to RUN.
- RUN:
  - Each cycle with core_task_grant=1: res_valid=1, res_data=core_task_res, res_addr=counter, res_id=win; then increment the counter.
  - The counter wraps modulo N; an overflow is recorded as a mismatch.
  - On core_task_end, go to DONE. If grant and end arrive in the same cycle, the word is forwarded first and then counted.
- DONE:
  - done[win]=1 for one cycle.
  - err=1 if the counted words ≠ N, or if the counter overflowed.
  - Clear gnt, set ptr=(win+1) mod NREQ, return to IDLE.
- Deasserting req[win] during a grant is ignored; the transaction always completes.
- New req bits that arrive during a grant wait for IDLE.
- core_task_grant or core_task_end outside RUN is ignored and produces no res_valid.
- Reset (asynchronous, any state):
  - State goes to IDLE, ptr=0.
  - gnt, done, err, res_valid, core_task_req, core_wr_ena, op_addr, core_wr_addr, res_addr, res_id, and all data outputs go to 0.
  - The core must share this reset (tie the core's rst_n to ~rst) so that a mid-task abort leaves no stale task running.

## Timing
- IDLE→gnt: 1 cycle after req is seen.
- LOAD: N+1 cycles (address pipeline of N cycles plus one data lag).
- START: 1 cycle.
- Request to core start: N+3 cycles from the cycle req is first sampled in IDLE.
- RUN length is set by the core (about 2200 cycles for K=128, N=32).
- res_valid follows core_task_grant combinationally-registered with a latency of 1 cycle.
- done follows core_task_end by 1 cycle.
- Back-to-back transactions: minimum of 1 IDLE cycle between done and the next gnt.

## Test plan
- Single requester 0, x=y=1, m=odd test modulus, N=32.
  - Required: gnt=0001; 32 writes at addresses 0..31 with data equal to the source words; one task_req pulse.
  - Required: 32 res_valid beats with res_id=0 and res_addr 0..31; done=0001 with err=0.
- req=1111 asserted together and held, ptr=0.
  - Required: grants in the order 0,1,2,3; then 0 again if still requesting.
  - Required: exactly one gnt bit high at any time.
- ptr=3 after serving requester 2, then req=1001.
  - Required: requester 3 is granted before requester 0 (wrap-around).
- Core model emits 31 result words then task_end.
  - Required: done pulses with err=1.
  - Repeat with 33 words: 33rd res_addr=0 and err=1.
- rst pulsed for 1 cycle during LOAD at address 10, and again during RUN.
  - Required: all outputs 0 asynchronously; state IDLE; no res_valid or done afterwards until a new req.
- Core grant/end pulses injected while in IDLE.
  - Required: no res_valid, no done, no state change.
